// File: rtl/monitor_capture_framer.sv
// Capture framer: wraps each channel-tagged Avalon-ST packet in a header/body/trailer frame.
// Optional timestamp word after the header when CAPTURE_FRAMER_TIMESTAMP_EN is defined.
module monitor_capture_framer #(
  parameter logic [7:0]  MAGIC_HDR   = 8'hA5,
  parameter logic [7:0]  MAGIC_TRL   = 8'h5A,
  parameter int unsigned SEQ_WIDTH   = 16,
  parameter int unsigned COUNT_WIDTH = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_channel,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  input  logic [1:0]  in_empty,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic [1:0]  out_empty,
  output logic [15:0] drop_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DROP_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
`ifdef CAPTURE_FRAMER_TIMESTAMP_EN
    S_TSTAMP,
`endif
    S_BODY,
    S_TRAILER
  } state_t;

  state_t                 state;
  logic                   cur_ch;
  logic [SEQ_WIDTH-1:0]   seq [2];
  logic [COUNT_WIDTH-1:0] beat_cnt;
  logic                   err;
  logic [1:0]             lat_empty;
  logic                   trl_sent;
`ifdef CAPTURE_FRAMER_TIMESTAMP_EN
  logic [DATA_W-1:0]      ts_cnt;
  logic [DATA_W-1:0]      ts_lat;
`endif

  logic load;
  logic first_beat;
  logic sop_err;

  assign load       = out_ready || !out_valid;
  assign first_beat = (beat_cnt == '0);
  assign sop_err    = in_valid && in_startofpacket && !first_beat;
  assign out_empty  = 2'b00;

  // IDLE drains orphan beats regardless of the output slice; BODY follows it
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_IDLE:  in_ready = !in_startofpacket;
      S_BODY:  in_ready = load && !(in_startofpacket && !first_beat);
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      cur_ch            <= 1'b0;
      seq[0]            <= '0;
      seq[1]            <= '0;
      beat_cnt          <= '0;
      err               <= 1'b0;
      lat_empty         <= 2'b00;
      trl_sent          <= 1'b0;
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      drop_count        <= '0;
`ifdef CAPTURE_FRAMER_TIMESTAMP_EN
      ts_cnt            <= '0;
      ts_lat            <= '0;
`endif
    end else begin
`ifdef CAPTURE_FRAMER_TIMESTAMP_EN
      ts_cnt <= ts_cnt + DATA_W'(1);
`endif
      // An emptied slice stays invalid unless a state below refills it
      if (load) begin
        out_valid         <= 1'b0;
        out_startofpacket <= 1'b0;
        out_endofpacket   <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (in_startofpacket) begin
              cur_ch <= in_channel;
              state  <= S_HEADER;
            end else if (drop_count != {DROP_W{1'b1}}) begin
              drop_count <= drop_count + DROP_W'(1);
            end
          end
        end

        S_HEADER: begin
          if (load) begin
            out_valid         <= 1'b1;
            out_data          <= {MAGIC_HDR, 7'd0, cur_ch, 16'(seq[cur_ch])};
            out_startofpacket <= 1'b1;
`ifdef CAPTURE_FRAMER_TIMESTAMP_EN
            ts_lat            <= ts_cnt;
            state             <= S_TSTAMP;
`else
            state             <= S_BODY;
`endif
          end
        end

`ifdef CAPTURE_FRAMER_TIMESTAMP_EN
        S_TSTAMP: begin
          if (load) begin
            out_valid <= 1'b1;
            out_data  <= ts_lat;
            state     <= S_BODY;
          end
        end
`endif

        S_BODY: begin
          if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            if (beat_cnt != {COUNT_WIDTH{1'b1}})
              beat_cnt <= beat_cnt + COUNT_WIDTH'(1);
            if (in_endofpacket) begin
              lat_empty <= in_empty;
              state     <= S_TRAILER;
            end
          end else if (load && sop_err) begin
            // Early sop closes this frame; the beat is held for the next one
            err   <= 1'b1;
            state <= S_TRAILER;
          end
        end

        S_TRAILER: begin
          if (!trl_sent) begin
            if (load) begin
              out_valid       <= 1'b1;
              out_data        <= {MAGIC_TRL, err, lat_empty, 1'b0, 20'(beat_cnt)};
              out_endofpacket <= 1'b1;
              trl_sent        <= 1'b1;
            end
          end else if (out_valid && out_ready) begin
            seq[cur_ch] <= seq[cur_ch] + SEQ_WIDTH'(1);
            beat_cnt    <= '0;
            err         <= 1'b0;
            lat_empty   <= 2'b00;
            trl_sent    <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
